// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: multiplexed common-anode 7-segment scan driver.
// Shadows packed 4-bit digits at frame boundaries so a frame never tears,
// decodes full hex, and optionally blanks leading zeros.
// Optional feature macro: SEG_BLINK_EN (adds a blink input and a frame counter).
module seven_seg_scan_driver #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
`ifdef SEG_BLINK_EN
  input  logic                  blink,
`endif
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned VW = 4 * DIGITS;

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [6:0]    SEG_OFF    = 7'h7F;

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [VW-1:0]     hold_q, hold_d;
  logic              pend_q, pend_d;
  logic [VW-1:0]     shadow_q, shadow_d;
  logic              frame_done_q, frame_done_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
`ifdef SEG_BLINK_EN
  logic [5:0]        frame_cnt_q, frame_cnt_d;
`endif

  logic              tc_c;
  logic              boundary_c;
  logic              zero_run_c;
  logic              cur_blank_c;
  logic [3:0]        cur_digit_c;

  // Active-low {g,f,e,d,c,b,a} hex decode.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan timing, capture/shadow handoff and registered display outputs.
  always_comb begin
    presc_d      = presc_q;
    idx_d        = idx_q;
    hold_d       = hold_q;
    pend_d       = pend_q;
    shadow_d     = shadow_q;
    frame_done_d = 1'b0;
    seg_d        = SEG_OFF;
    an_d         = '1;
    zero_run_c   = 1'b1;
    cur_blank_c  = 1'b0;
    cur_digit_c  = 4'h0;
`ifdef SEG_BLINK_EN
    frame_cnt_d  = frame_cnt_q;
`endif

    tc_c       = (presc_q == PRESC_LAST);
    boundary_c = tc_c && (idx_q == IDX_LAST);

    presc_d = tc_c ? '0 : presc_q + PW'(1);
    if (tc_c) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    // A load on the boundary itself bypasses hold and goes straight to shadow.
    if (boundary_c) begin
      if (load) begin
        shadow_d = value;
        hold_d   = value;
        pend_d   = 1'b0;
      end else if (pend_q) begin
        shadow_d = hold_q;
        pend_d   = 1'b0;
      end
    end else if (load) begin
      hold_d = value;
      pend_d = 1'b1;
    end

    frame_done_d = boundary_c;

    // Walk digits from the most significant down, tracking the zero run.
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      zero_run_c = zero_run_c && (shadow_q[4*k +: 4] == 4'h0);
      if (idx_q == IW'(k)) begin
        cur_digit_c = shadow_q[4*k +: 4];
        cur_blank_c = blank_lz && zero_run_c && (k > 0);
        an_d[k]     = 1'b0;
      end
    end

    seg_d = hex_to_seg(cur_digit_c);
    if (cur_blank_c) begin
      seg_d = SEG_OFF;
      an_d  = '1;
    end

`ifdef SEG_BLINK_EN
    if (boundary_c) begin
      frame_cnt_d = frame_cnt_q + 6'd1;
    end
    if (blink && frame_cnt_q[5]) begin
      seg_d = SEG_OFF;
      an_d  = '1;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      hold_q       <= '0;
      pend_q       <= 1'b0;
      shadow_q     <= '0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= '1;
`ifdef SEG_BLINK_EN
      frame_cnt_q  <= '0;
`endif
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      pend_q       <= pend_d;
      shadow_q     <= shadow_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
`ifdef SEG_BLINK_EN
      frame_cnt_q  <= frame_cnt_d;
`endif
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
